dsd_timer_cfg_master: RTL and testbench

//  Avalon-MM master that drives the system interval timer (16-bit, 6-register slave).

---
 rtl/dsd_timer_cfg_master.sv | 276 +++++++++++++++++++++++++++
 tb/tb_dsd_timer_cfg_master.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsd_timer_cfg_master.sv
// dsd_timer_cfg_master
// Avalon-MM master for the 16-bit, 6-register interval timer. Programs the
// 32-bit period, starts/stops the counter, clears the timeout status when the
// level IRQ fires (counting serviced timeouts) and reads 32-bit counter snapshots.
module dsd_timer_cfg_master #(
    parameter int READ_LATENCY = 1,
    parameter int TICK_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [2:0]        avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              timer_irq,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              cmd_ready,
    output logic              running,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count
);

    // Timer register map (word addresses).
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PERL   = 3'd2;
    localparam logic [2:0] ADDR_PERH   = 3'd3;
    localparam logic [2:0] ADDR_SNAPL  = 3'd4;
    localparam logic [2:0] ADDR_SNAPH  = 3'd5;

    // Control register values: ITO|START (CONT added from r_cont), and STOP.
    localparam logic [15:0] CTRL_RUN  = 16'h0005;
    localparam logic [15:0] CTRL_STOP = 16'h0008;

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR_STS,
        WR_STOP,
        SNAP_WR,
        SNAP_RL,
        SNAP_WL,
        SNAP_RH,
        SNAP_WH
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [31:0]         r_period;
    logic                r_cont;
    logic                r_snap_ret_run;
    logic [15:0]         r_snap_lo;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_active;
    logic                r_running;
    logic                r_snap_valid;
    logic [31:0]         r_snap_value;
    logic                r_tick;
    logic [TICK_W-1:0]   r_tick_count;

    logic                w_accept;
    logic                w_lat_done;
    logic                w_cmd_ready;
    logic                w_start_acc;
    logic                w_snap_acc;

    // A transfer completes when a request is up and the slave is not stalling.
    assign w_accept   = (avm_write || avm_read) && !avm_waitrequest;
    // Read data is valid READ_LATENCY cycles after acceptance; the wait-for-data
    // state is entered one cycle after acceptance with the counter at zero.
    assign w_lat_done = (r_lat_cnt == LAT_W'(READ_LATENCY - 1));

    assign cmd_ready  = w_cmd_ready;
    assign running    = r_running;
    assign snap_valid = r_snap_valid;
    assign snap_value = r_snap_value;
    assign tick       = r_tick;
    assign tick_count = r_tick_count;

    // State register; async reset returns to IDLE, which also drops any request.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and bus request outputs, derived purely from state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state  = r_state;
        avm_address   = ADDR_STATUS;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_writedata = 16'h0000;
        w_start_acc   = 1'b0;
        w_snap_acc    = 1'b0;
        w_cmd_ready   = r_active &&
                        ((r_state == IDLE) || ((r_state == RUN) && !timer_irq));

        unique case (r_state)
            IDLE, RUN: begin
                if ((r_state == RUN) && timer_irq) begin
                    w_next_state = CLR_STS;
                end else if (w_cmd_ready) begin
                    if (cfg_stop) begin
                        w_next_state = WR_STOP;
                    end else if (cfg_start) begin
                        w_next_state = WR_PL;
                        w_start_acc  = 1'b1;
                    end else if (snap_req) begin
                        w_next_state = SNAP_WR;
                        w_snap_acc   = 1'b1;
                    end
                end
            end
            WR_PL: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_PERL;
                avm_writedata = r_period[15:0];
                if (!avm_waitrequest) w_next_state = WR_PH;
            end
            WR_PH: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_PERH;
                avm_writedata = r_period[31:16];
                if (!avm_waitrequest) w_next_state = WR_CTRL;
            end
            WR_CTRL: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_CTRL;
                avm_writedata = CTRL_RUN | {14'd0, r_cont, 1'b0};
                if (!avm_waitrequest) w_next_state = RUN;
            end
            CLR_STS: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_STATUS;
                if (!avm_waitrequest) w_next_state = r_cont ? RUN : IDLE;
            end
            WR_STOP: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_CTRL;
                avm_writedata = CTRL_STOP;
                if (!avm_waitrequest) w_next_state = IDLE;
            end
            SNAP_WR: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_SNAPL;
                if (!avm_waitrequest) w_next_state = SNAP_RL;
            end
            SNAP_RL: begin
                avm_read      = 1'b1;
                avm_address   = ADDR_SNAPL;
                if (!avm_waitrequest) w_next_state = SNAP_WL;
            end
            SNAP_WL: begin
                if (w_lat_done) w_next_state = SNAP_RH;
            end
            SNAP_RH: begin
                avm_read      = 1'b1;
                avm_address   = ADDR_SNAPH;
                if (!avm_waitrequest) w_next_state = SNAP_WH;
            end
            SNAP_WH: begin
                if (w_lat_done) w_next_state = r_snap_ret_run ? RUN : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Hold off commands for the first cycle after reset so cmd_ready is 0 in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // Latch command operands at acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period       <= 32'd0;
            r_cont         <= 1'b0;
            r_snap_ret_run <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_period <= cfg_period;
                r_cont   <= cfg_continuous;
            end
            if (w_snap_acc) begin
                r_snap_ret_run <= (r_state == RUN);
            end
        end
    end

    // Read-latency counter: cleared on read acceptance, advances while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
        end else if (w_accept && avm_read) begin
            r_lat_cnt <= '0;
        end else if (((r_state == SNAP_WL) || (r_state == SNAP_WH)) && !w_lat_done) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
        end
    end

    // Running flag: a period write stops the timer, the ctrl write restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_running <= 1'b0;
        end else if (w_accept) begin
            unique case (r_state)
                WR_PL:   r_running <= 1'b0;
                WR_CTRL: r_running <= 1'b1;
                CLR_STS: r_running <= r_cont;
                WR_STOP: r_running <= 1'b0;
                default: r_running <= r_running;
            endcase
        end
    end

    // Serviced-timeout pulse and wrapping counter; a new start clears the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_tick <= (r_state == CLR_STS) && w_accept;
            if (w_start_acc) begin
                r_tick_count <= '0;
            end else if ((r_state == CLR_STS) && w_accept) begin
                r_tick_count <= r_tick_count + TICK_W'(1);
            end
        end
    end

    // Snapshot capture: low half first, then publish {high, low} with a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_lo    <= 16'h0000;
            r_snap_value <= 32'd0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= 1'b0;
            if ((r_state == SNAP_WL) && w_lat_done) begin
                r_snap_lo <= avm_readdata;
            end
            if ((r_state == SNAP_WH) && w_lat_done) begin
                r_snap_value <= {avm_readdata, r_snap_lo};
                r_snap_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsd_timer_cfg_master.sv
// tb_dsd_timer_cfg_master
// Directed plus randomized stimulus against a transaction-level model of the
// timer master. A behavioural timer slave logs every completed bus transfer.
module tb_dsd_timer_cfg_master;

    localparam int RL = 1;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    avm_address;
    logic          avm_write;
    logic          avm_read;
    logic [15:0]   avm_writedata;
    logic [15:0]   avm_readdata = 16'h0000;
    logic          avm_waitrequest = 1'b0;
    logic          timer_irq = 1'b0;
    logic          cfg_start;
    logic [31:0]   cfg_period;
    logic          cfg_continuous;
    logic          cfg_stop;
    logic          snap_req;
    logic          cmd_ready;
    logic          running;
    logic          snap_valid;
    logic [31:0]   snap_value;
    logic          tick;
    logic [TW-1:0] tick_count;

    always #5 clk = ~clk;

    dsd_timer_cfg_master #(
        .READ_LATENCY (RL),
        .TICK_W       (TW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .timer_irq       (timer_irq),
        .cfg_start       (cfg_start),
        .cfg_period      (cfg_period),
        .cfg_continuous  (cfg_continuous),
        .cfg_stop        (cfg_stop),
        .snap_req        (snap_req),
        .cmd_ready       (cmd_ready),
        .running         (running),
        .snap_valid      (snap_valid),
        .snap_value      (snap_value),
        .tick            (tick),
        .tick_count      (tick_count)
    );

    typedef struct {
        bit        wr;
        bit [2:0]  addr;
        bit [15:0] data;
        int        cyc;
    } xfer_t;

    int checks = 0;
    int errors = 0;

    // Slave controls, written only by the stimulus block.
    int        wait_pct = 0;
    int        stall_a3 = 0;
    bit [15:0] snap_lo_v = 16'h0000;
    bit [15:0] snap_hi_v = 16'h0000;
    int        irq_req_cnt = 0;

    // Slave/monitor state, written only by the slave block.
    xfer_t     log_q[$];
    int        cyc = 0;
    int        irq_done_cnt = 0;
    int        s_cnt = 0;
    bit        raise_next = 1'b0;
    bit [15:0] per_l = 16'h0000;
    bit [15:0] per_h = 16'h0000;
    bit        rd_pipe_v [RL];
    bit [15:0] rd_pipe_d [RL];
    bit        acc_rd_prev = 1'b0;
    bit [15:0] acc_rd_data = 16'h0000;
    int        r3_cycles = 0;
    int        r3_changes = 0;
    bit        r3_prev = 1'b0;
    bit [15:0] r3_prev_d = 16'h0000;
    int        snap_pulses = 0;
    int        tick_pulses = 0;
    bit [31:0] snap_seen = 32'd0;

    // Reference model, owned by the stimulus block.
    xfer_t     exp_q[$];
    int        log_rd = 0;
    bit        m_running = 1'b0;
    bit        m_cont = 1'b0;
    int        m_ticks = 0;
    int        m_tick_total = 0;
    bit [31:0] m_snap = 32'd0;
    int        m_snaps = 0;

    // Behavioural timer slave and bus monitor, acting mid-cycle on the falling edge.
    always @(negedge clk) begin
        xfer_t x;
        cyc++;
        if (!reset_n) begin
            timer_irq       = 1'b0;
            raise_next      = 1'b0;
            acc_rd_prev     = 1'b0;
            s_cnt           = 0;
            irq_done_cnt    = irq_req_cnt;
            avm_waitrequest = 1'b0;
            avm_readdata    = 16'h0000;
            r3_prev         = 1'b0;
            for (int i = 0; i < RL; i++) rd_pipe_v[i] = 1'b0;
        end else begin
            for (int i = RL - 1; i > 0; i--) begin
                rd_pipe_v[i] = rd_pipe_v[i-1];
                rd_pipe_d[i] = rd_pipe_d[i-1];
            end
            rd_pipe_v[0] = acc_rd_prev;
            rd_pipe_d[0] = acc_rd_data;
            acc_rd_prev  = 1'b0;
            avm_readdata = rd_pipe_v[RL-1] ? rd_pipe_d[RL-1] : 16'($urandom);

            if (raise_next || (irq_done_cnt != irq_req_cnt)) begin
                timer_irq    = 1'b1;
                raise_next   = 1'b0;
                irq_done_cnt = irq_req_cnt;
            end

            if (avm_write && (avm_address == 3'd3) && (s_cnt < stall_a3)) begin
                avm_waitrequest = 1'b1;
                s_cnt++;
            end else begin
                avm_waitrequest = ($urandom_range(99) < wait_pct);
                if (!(avm_write && (avm_address == 3'd3))) s_cnt = 0;
            end

            if (avm_write && (avm_address == 3'd3)) begin
                r3_cycles++;
                if (r3_prev && (avm_writedata != r3_prev_d)) r3_changes++;
                r3_prev   = 1'b1;
                r3_prev_d = avm_writedata;
            end else begin
                r3_prev = 1'b0;
            end

            if ((avm_write || avm_read) && !avm_waitrequest) begin
                x.wr   = avm_write;
                x.addr = avm_address;
                x.data = avm_write ? avm_writedata : 16'h0000;
                x.cyc  = cyc;
                log_q.push_back(x);
                if (avm_read) begin
                    acc_rd_prev = 1'b1;
                    acc_rd_data = (avm_address == 3'd4) ? snap_lo_v :
                                  (avm_address == 3'd5) ? snap_hi_v : 16'h0000;
                end else begin
                    case (avm_address)
                        3'd0: timer_irq = 1'b0;
                        3'd1: begin
                            if (avm_writedata[3]) timer_irq = 1'b0;
                            if (avm_writedata[2] && ({per_h, per_l} == 32'd0)) raise_next = 1'b1;
                        end
                        3'd2: per_l = avm_writedata;
                        3'd3: per_h = avm_writedata;
                        default: ;
                    endcase
                end
            end

            if (snap_valid) begin
                snap_pulses++;
                snap_seen = snap_value;
            end
            if (tick) tick_pulses++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_exp(input bit wr, input bit [2:0] addr, input bit [15:0] data);
        xfer_t x;
        x.wr   = wr;
        x.addr = addr;
        x.data = data;
        x.cyc  = 0;
        exp_q.push_back(x);
    endtask

    task automatic compare_log(input string tag);
        int n;
        n = log_q.size() - log_rd;
        check({tag, " xfer count"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (log_rd + i < log_q.size()) begin
                check($sformatf("%s xfer[%0d]", tag, i),
                      {log_q[log_rd+i].wr, log_q[log_rd+i].addr, log_q[log_rd+i].data},
                      {exp_q[i].wr, exp_q[i].addr, exp_q[i].data});
            end
        end
        log_rd = log_q.size();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, " running"}, running, m_running);
        check({tag, " tick_count"}, tick_count, 64'(m_ticks % (1 << TW)));
        check({tag, " tick pulses"}, 64'(tick_pulses), 64'(m_tick_total));
        check({tag, " snap_value"}, snap_value, m_snap);
        check({tag, " snap pulses"}, 64'(snap_pulses), 64'(m_snaps));
        compare_log(tag);
    endtask

    task automatic wait_done(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; (i < 400) && !done; i++) begin
            step();
            if (cmd_ready && !timer_irq && !avm_write && !avm_read) done = 1'b1;
        end
        check({tag, " settle"}, done, 1'b1);
    endtask

    task automatic wait_ready(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; (i < 10) && !done; i++) begin
            step();
            if (cmd_ready) done = 1'b1;
        end
        check({tag, " cmd_ready"}, done, 1'b1);
    endtask

    task automatic serviced();
        push_exp(1'b1, 3'd0, 16'h0000);
        m_ticks++;
        m_tick_total++;
        if (!m_cont) m_running = 1'b0;
    endtask

    task automatic do_start(input bit [31:0] p, input bit cont);
        cfg_period     = p;
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        step();
        cfg_start      = 1'b0;
        cfg_period     = $urandom;
        cfg_continuous = 1'($urandom);
        push_exp(1'b1, 3'd2, p[15:0]);
        push_exp(1'b1, 3'd3, p[31:16]);
        push_exp(1'b1, 3'd1, cont ? 16'h0007 : 16'h0005);
        m_running = 1'b1;
        m_cont    = cont;
        m_ticks   = 0;
        if (p == 32'd0) serviced();
        wait_done("start");
    endtask

    task automatic do_stop();
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        push_exp(1'b1, 3'd1, 16'h0008);
        m_running = 1'b0;
        wait_done("stop");
    endtask

    task automatic do_start_stop();
        cfg_period     = $urandom;
        cfg_continuous = 1'($urandom);
        cfg_start      = 1'b1;
        cfg_stop       = 1'b1;
        step();
        cfg_start      = 1'b0;
        cfg_stop       = 1'b0;
        push_exp(1'b1, 3'd1, 16'h0008);
        m_running = 1'b0;
        wait_done("start+stop");
    endtask

    task automatic do_irq();
        irq_req_cnt++;
        serviced();
        wait_done("irq");
    endtask

    task automatic do_snap(input bit [15:0] lo, input bit [15:0] hi, input bit with_irq);
        snap_lo_v = lo;
        snap_hi_v = hi;
        snap_req  = 1'b1;
        step();
        snap_req  = 1'b0;
        push_exp(1'b1, 3'd4, 16'h0000);
        push_exp(1'b0, 3'd4, 16'h0000);
        push_exp(1'b0, 3'd5, 16'h0000);
        m_snap = {hi, lo};
        m_snaps++;
        if (with_irq) begin
            irq_req_cnt++;
            serviced();
        end
        wait_done("snap");
    endtask

    initial begin
        int  op;
        bit  found;
        reset_n        = 1'b0;
        cfg_start      = 1'b0;
        cfg_period     = 32'd0;
        cfg_continuous = 1'b0;
        cfg_stop       = 1'b0;
        snap_req       = 1'b0;
        repeat (3) step();

        // Reset state.
        check("rst avm_write", avm_write, 1'b0);
        check("rst avm_read", avm_read, 1'b0);
        check("rst avm_address", avm_address, 3'd0);
        check("rst avm_writedata", avm_writedata, 16'h0000);
        check("rst cmd_ready", cmd_ready, 1'b0);
        check("rst running", running, 1'b0);
        check("rst snap_valid", snap_valid, 1'b0);
        check("rst snap_value", snap_value, 32'd0);
        check("rst tick", tick, 1'b0);
        check("rst tick_count", tick_count, '0);
        reset_n = 1'b1;
        wait_ready("post-reset");

        // Zero-wait start: three writes on consecutive cycles.
        do_start(32'h0001_86A0, 1'b1);
        if (log_q.size() >= log_rd + 3) begin
            check("t1 gap PL-PH", 64'(log_q[log_rd+1].cyc - log_q[log_rd].cyc), 64'd1);
            check("t1 gap PH-CTRL", 64'(log_q[log_rd+2].cyc - log_q[log_rd+1].cyc), 64'd1);
        end
        check_state("t1");

        // Three-cycle stall on the high-period write: held 4 cycles, written once.
        begin
            int base_c;
            int base_x;
            bit [31:0] p;
            base_c   = r3_cycles;
            base_x   = r3_changes;
            stall_a3 = 3;
            p        = $urandom | 32'h1;
            do_start(p, 1'b1);
            stall_a3 = 0;
            check("t2 addr3 held cycles", 64'(r3_cycles - base_c), 64'd4);
            check("t2 addr3 data changes", 64'(r3_changes - base_x), 64'd0);
            check_state("t2");
        end

        // Three timeouts in continuous mode.
        repeat (3) do_irq();
        check("t3 tick_count", tick_count, TW'(3));
        check_state("t3");

        // One-shot: single timeout ends the run.
        do_start($urandom | 32'h1, 1'b0);
        do_irq();
        check_state("t4");

        // Snapshot from IDLE with fixed halves.
        do_snap(16'h1234, 16'h0056, 1'b0);
        check("t5 snap at pulse", snap_seen, 32'h0056_1234);
        check_state("t5");

        // Snapshot from RUN with an IRQ arriving mid-sequence.
        do_start($urandom | 32'h1, 1'b1);
        do_snap(16'($urandom), 16'($urandom), 1'b1);
        check_state("t6");

        // Simultaneous start and stop in RUN: only the stop is written.
        do_start($urandom | 32'h1, 1'b1);
        do_start_stop();
        check_state("t7");

        // IRQ and snap_req in the same cycle: status clear first, snap dropped.
        do_start($urandom | 32'h1, 1'b1);
        irq_req_cnt++;
        step();
        check("t8 cmd_ready with irq", cmd_ready, 1'b0);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        serviced();
        wait_done("t8");
        check_state("t8");

        // Zero period: immediate timeout, serviced normally.
        do_start(32'd0, 1'b1);
        check_state("t9 cont");
        do_start(32'd0, 1'b0);
        check_state("t9 oneshot");

        // tick_count wraps modulo 2^TW.
        do_start($urandom | 32'h1, 1'b1);
        repeat ((1 << TW) + 1) do_irq();
        check_state("t10 wrap");

        // Randomized command mix under random stalls.
        for (int it = 0; it < 30; it++) begin
            wait_pct = $urandom_range(40);
            op       = $urandom_range(4);
            case (op)
                0: do_start(($urandom_range(7) == 0) ? 32'd0 : 32'($urandom), 1'($urandom));
                1: do_stop();
                2: do_snap(16'($urandom), 16'($urandom), m_running && ($urandom_range(1) == 1));
                3: if (m_running) do_irq(); else do_stop();
                default: do_start_stop();
            endcase
            check_state($sformatf("rnd%0d", it));
        end
        wait_pct = 0;

        // Async reset in the middle of a stalled high-period write.
        stall_a3       = 1000;
        cfg_period     = $urandom | 32'h1;
        cfg_continuous = 1'b1;
        cfg_start      = 1'b1;
        step();
        cfg_start      = 1'b0;
        found          = 1'b0;
        for (int i = 0; (i < 20) && !found; i++) begin
            if (avm_write && (avm_address == 3'd3)) found = 1'b1;
            else step();
        end
        check("t11 reached stall", found, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t11 avm_write", avm_write, 1'b0);
        check("t11 avm_read", avm_read, 1'b0);
        check("t11 avm_address", avm_address, 3'd0);
        check("t11 avm_writedata", avm_writedata, 16'h0000);
        check("t11 running", running, 1'b0);
        check("t11 cmd_ready", cmd_ready, 1'b0);
        check("t11 tick_count", tick_count, '0);
        check("t11 snap_value", snap_value, 32'd0);
        stall_a3 = 0;
        step();
        step();
        reset_n   = 1'b1;
        m_running = 1'b0;
        m_ticks   = 0;
        m_snap    = 32'd0;
        log_rd    = log_q.size();
        exp_q.delete();
        wait_ready("t11 release");
        do_start($urandom | 32'h1, 1'b1);
        check_state("t11 restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
